autosa_dmaif_rd_router: RTL and testbench

Parametrised read-DMA interface that steers one client read-request stream to one of NUM_PORTS memory interfaces (mcif, cvif, ...), selected per request by a ram-type field. It merges the per-port response streams back into a single client stream, strictly in request order, including multi-beat reads. It also routes the client's credit/latency-FIFO pop pulse to the port that owns the response. It generalises the two-port SDP RDMA DMA wrapper with N ports, in-order multi-beat reassembly, an outstanding-request limit and error reporting.

---
 rtl/autosa_dmaif_rd_router.sv | 148 ++++++++++++++
 tb/tb_autosa_dmaif_rd_router.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/autosa_dmaif_rd_router.sv
// Read-DMA router: steers client read requests to one of NUM_PORTS memory interfaces and
// merges the per-port responses back into a single stream in request order.
module autosa_dmaif_rd_router #(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned SEL_W     = 1,
    parameter int unsigned REQ_W     = 79,
    parameter int unsigned RSP_W     = 257,
    parameter int unsigned LEN_LSB   = 64,
    parameter int unsigned LEN_W     = 15,
    parameter int unsigned ORD_DEPTH = 16
) (
    input  logic                           autosa_core_clk,
    input  logic                           autosa_core_rst,
    input  logic [SEL_W-1:0]               dma_rd_req_ram_type,
    input  logic [REQ_W-1:0]               dma_rd_req_pd,
    input  logic                           dma_rd_req_vld,
    output logic                           dma_rd_req_rdy,
    output logic [NUM_PORTS*REQ_W-1:0]     port_rd_req_pd,
    output logic [NUM_PORTS-1:0]           port_rd_req_valid,
    input  logic [NUM_PORTS-1:0]           port_rd_req_ready,
    input  logic [NUM_PORTS*RSP_W-1:0]     port_rd_rsp_pd,
    input  logic [NUM_PORTS-1:0]           port_rd_rsp_valid,
    output logic [NUM_PORTS-1:0]           port_rd_rsp_ready,
    output logic [RSP_W-1:0]               dma_rd_rsp_pd,
    output logic                           dma_rd_rsp_vld,
    input  logic                           dma_rd_rsp_rdy,
    input  logic [SEL_W-1:0]               dma_rd_cdt_ram_type,
    input  logic                           dma_rd_cdt_lat_fifo_pop,
    output logic [NUM_PORTS-1:0]           port_rd_cdt_lat_fifo_pop,
    output logic [$clog2(ORD_DEPTH):0]     outstanding_cnt,
    output logic                           sel_err
);

    localparam int unsigned PTR_W = $clog2(ORD_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [PTR_W:0]   PTR_ONE = (PTR_W + 1)'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    // Order FIFO: one entry per outstanding request, {target port, beats-minus-one}
    logic [SEL_W-1:0] ord_sel_q [ORD_DEPTH];
    logic [LEN_W-1:0] ord_len_q [ORD_DEPTH];
    logic [PTR_W:0]   wr_ptr_q;
    logic [PTR_W:0]   rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [LEN_W-1:0] beat_q;

    logic             ord_full;
    logic             ord_empty;
    logic             sel_ok;
    logic             req_port_rdy;
    logic             req_acc;
    logic             rsp_acc;
    logic             ord_pop;
    logic [SEL_W-1:0] head_sel;
    logic [LEN_W-1:0] head_len;
    logic [NUM_PORTS-1:0] cdt_pop_d;

    assign ord_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                       (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign ord_empty = (wr_ptr_q == rd_ptr_q);
    assign head_sel  = ord_sel_q[rd_ptr_q[PTR_W-1:0]];
    assign head_len  = ord_len_q[rd_ptr_q[PTR_W-1:0]];

    assign port_rd_req_pd = {NUM_PORTS{dma_rd_req_pd}};

    always_comb begin
        port_rd_req_valid = '0;
        req_port_rdy      = 1'b0;
        sel_ok            = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (dma_rd_req_ram_type == SEL_W'(i)) begin
                sel_ok               = 1'b1;
                req_port_rdy         = port_rd_req_ready[i];
                port_rd_req_valid[i] = dma_rd_req_vld & ~ord_full;
            end
        end
    end

    assign dma_rd_req_rdy = req_port_rdy & ~ord_full;
    assign req_acc        = dma_rd_req_vld & dma_rd_req_rdy;

    // Only the head port is ever listened to, which is what keeps responses in order
    always_comb begin
        dma_rd_rsp_vld    = 1'b0;
        dma_rd_rsp_pd     = '0;
        port_rd_rsp_ready = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!ord_empty && head_sel == SEL_W'(i)) begin
                dma_rd_rsp_vld       = port_rd_rsp_valid[i];
                dma_rd_rsp_pd        = port_rd_rsp_pd[i*RSP_W +: RSP_W];
                port_rd_rsp_ready[i] = dma_rd_rsp_rdy;
            end
        end
    end

    assign rsp_acc = dma_rd_rsp_vld & dma_rd_rsp_rdy;
    assign ord_pop = rsp_acc & (beat_q == head_len);

    always_comb begin
        cdt_pop_d = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (dma_rd_cdt_ram_type == SEL_W'(i)) begin
                cdt_pop_d[i] = dma_rd_cdt_lat_fifo_pop;
            end
        end
    end

    always_ff @(posedge autosa_core_clk) begin
        if (req_acc) begin
            ord_sel_q[wr_ptr_q[PTR_W-1:0]] <= dma_rd_req_ram_type;
            ord_len_q[wr_ptr_q[PTR_W-1:0]] <= dma_rd_req_pd[LEN_LSB +: LEN_W];
        end
    end

    always_ff @(posedge autosa_core_clk) begin
        if (autosa_core_rst) begin
            wr_ptr_q                 <= '0;
            rd_ptr_q                 <= '0;
            cnt_q                    <= '0;
            beat_q                   <= '0;
            sel_err                  <= 1'b0;
            port_rd_cdt_lat_fifo_pop <= '0;
        end else begin
            if (req_acc) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (ord_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({req_acc, ord_pop})
                2'b10:   cnt_q <= cnt_q + CNT_ONE;
                2'b01:   cnt_q <= cnt_q - CNT_ONE;
                default: cnt_q <= cnt_q;
            endcase
            if (rsp_acc) begin
                beat_q <= ord_pop ? '0 : beat_q + LEN_ONE;
            end
            if (dma_rd_req_vld && !sel_ok) begin
                sel_err <= 1'b1;
            end
            port_rd_cdt_lat_fifo_pop <= cdt_pop_d;
        end
    end

    assign outstanding_cnt = cnt_q;

endmodule

// File: tb/tb_autosa_dmaif_rd_router.sv
// Bench for autosa_dmaif_rd_router: vector table for request routing, bench-side port
// responders and an in-order response scoreboard for the merged stream.
module tb_autosa_dmaif_rd_router;

    localparam int unsigned NP  = 2;
    localparam int unsigned SW  = 2;
    localparam int unsigned RQW = 79;
    localparam int unsigned RSW = 32;
    localparam int unsigned OD  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [SW-1:0]     req_type;
    logic [RQW-1:0]    req_pd;
    logic              req_vld;
    logic              req_rdy;
    logic [NP*RQW-1:0] port_req_pd;
    logic [NP-1:0]     port_req_valid;
    logic [NP-1:0]     port_rdy;
    logic [NP*RSW-1:0] rsp_pd_bus;
    logic [NP-1:0]     rsp_valid_bus;
    logic [NP-1:0]     port_rsp_ready;
    logic [RSW-1:0]    rsp_pd;
    logic              rsp_vld;
    logic              rsp_rdy;
    logic [SW-1:0]     cdt_type;
    logic              cdt_pop;
    logic [NP-1:0]     port_cdt_pop;
    logic [4:0]        outstanding_cnt;
    logic              sel_err;

    always #5 clk = ~clk;

    autosa_dmaif_rd_router #(
        .NUM_PORTS (NP),
        .SEL_W     (SW),
        .REQ_W     (RQW),
        .RSP_W     (RSW),
        .LEN_LSB   (64),
        .LEN_W     (15),
        .ORD_DEPTH (OD)
    ) dut (
        .autosa_core_clk          (clk),
        .autosa_core_rst          (rst),
        .dma_rd_req_ram_type      (req_type),
        .dma_rd_req_pd            (req_pd),
        .dma_rd_req_vld           (req_vld),
        .dma_rd_req_rdy           (req_rdy),
        .port_rd_req_pd           (port_req_pd),
        .port_rd_req_valid        (port_req_valid),
        .port_rd_req_ready        (port_rdy),
        .port_rd_rsp_pd           (rsp_pd_bus),
        .port_rd_rsp_valid        (rsp_valid_bus),
        .port_rd_rsp_ready        (port_rsp_ready),
        .dma_rd_rsp_pd            (rsp_pd),
        .dma_rd_rsp_vld           (rsp_vld),
        .dma_rd_rsp_rdy           (rsp_rdy),
        .dma_rd_cdt_ram_type      (cdt_type),
        .dma_rd_cdt_lat_fifo_pop  (cdt_pop),
        .port_rd_cdt_lat_fifo_pop (port_cdt_pop),
        .outstanding_cnt          (outstanding_cnt),
        .sel_err                  (sel_err)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [RSW-1:0] data;
        bit             last;
    } exp_t;

    exp_t           exp_q[$];
    logic [RSW-1:0] pend0[$];
    logic [RSW-1:0] pend1[$];
    logic [7:0]     rid = 8'd0;
    int             exp_cnt = 0;
    int             rx_cnt = 0;
    logic [NP-1:0]  en = '0;
    logic [NP-1:0]  stray = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [SW-1:0] t, input int len);
        req_type = t;
        req_pd   = {15'(len), 32'($urandom), 32'($urandom)};
    endtask

    task automatic push_model(input logic [SW-1:0] t, input int len);
        logic [RSW-1:0] d;
        for (int b = 0; b <= len; b++) begin
            d = {8'(t), rid, 16'(b)};
            if (t == 0) pend0.push_back(d);
            else        pend1.push_back(d);
            exp_q.push_back('{d, b == len});
        end
        rid++;
        exp_cnt++;
    endtask

    // Called at posedge+1; returns at posedge+1 with req_vld low
    task automatic send_req(input logic [SW-1:0] t, input int len);
        bit ok = 1'b0;
        set_req(t, len);
        req_vld = 1'b1;
        for (int c = 0; c < 8 && !ok; c++) begin
            @(negedge clk);
            if (req_rdy) begin
                ok = 1'b1;
                push_model(t, len);
            end
            cyc();
        end
        req_vld = 1'b0;
        chk("req_accept", 128'(ok), 128'd1);
    endtask

    task automatic drain(input int budget, input bit rnd);
        int c = 0;
        en = 2'b11;
        while ((exp_q.size() != 0 || outstanding_cnt != 0) && c < budget) begin
            if (rnd) rsp_rdy = 1'($urandom_range(0, 1));
            cyc();
            c++;
            chk("cnt_track", 128'(outstanding_cnt), 128'(exp_cnt));
        end
        rsp_rdy = 1'b1;
        en      = 2'b00;
        chk("drain_budget", 128'(c < budget), 128'd1);
        chk("drain_cnt", 128'(outstanding_cnt), 128'd0);
        chk("drain_left", 128'(exp_q.size()), 128'd0);
    endtask

    // Port responders: present the oldest pending beat of each port
    always @(posedge clk) begin
        #2;
        rsp_valid_bus[0]  = stray[0] || (en[0] && pend0.size() > 0);
        rsp_valid_bus[1]  = stray[1] || (en[1] && pend1.size() > 0);
        rsp_pd_bus[31:0]  = (pend0.size() > 0) ? pend0[0] : 32'hdead0000;
        rsp_pd_bus[63:32] = (pend1.size() > 0) ? pend1[0] : 32'hdead0001;
    end

    // Handshakes are sampled mid-cycle; they complete at the following posedge
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            pend0.delete();
            pend1.delete();
            exp_q.delete();
            exp_cnt = 0;
        end else begin
            if (rsp_valid_bus[0] && port_rsp_ready[0] && pend0.size() > 0) void'(pend0.pop_front());
            if (rsp_valid_bus[1] && port_rsp_ready[1] && pend1.size() > 0) void'(pend1.pop_front());
            if (rsp_vld && rsp_rdy) begin
                rx_cnt++;
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 128'(rsp_pd), 128'hffff_ffff_ffff);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_data", 128'(rsp_pd), 128'(e.data));
                    if (e.last) exp_cnt--;
                end
            end
        end
    end

    typedef struct {
        logic [SW-1:0] rtype;
        logic          vld;
        logic [NP-1:0] prdy;
        logic          exp_rdy;
        logic [NP-1:0] exp_valid;
    } vec_t;

    vec_t vt[8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int c;
        logic [SW-1:0] ct [3];
        logic [NP-1:0] ce [3];

        vt[0] = '{2'd0, 1'b1, 2'b11, 1'b1, 2'b01};
        vt[1] = '{2'd1, 1'b1, 2'b11, 1'b1, 2'b10};
        vt[2] = '{2'd0, 1'b1, 2'b10, 1'b0, 2'b01};
        vt[3] = '{2'd1, 1'b1, 2'b01, 1'b0, 2'b10};
        vt[4] = '{2'd0, 1'b0, 2'b11, 1'b1, 2'b00};
        vt[5] = '{2'd2, 1'b1, 2'b11, 1'b0, 2'b00};
        vt[6] = '{2'd3, 1'b1, 2'b11, 1'b0, 2'b00};
        vt[7] = '{2'd1, 1'b0, 2'b00, 1'b0, 2'b00};

        rst = 1'b1; req_vld = 1'b0; req_type = '0; req_pd = '0; port_rdy = 2'b11;
        rsp_rdy = 1'b1; cdt_type = '0; cdt_pop = 1'b0;
        rsp_valid_bus = '0; rsp_pd_bus = '0;
        repeat (3) cyc();
        rst = 1'b0;
        #2;
        chk("rst_req_rdy", 128'(req_rdy), 128'd1);
        chk("rst_req_valid", 128'(port_req_valid), 128'd0);
        chk("rst_rsp_vld", 128'(rsp_vld), 128'd0);
        chk("rst_rsp_ready", 128'(port_rsp_ready), 128'd0);
        chk("rst_cdt", 128'(port_cdt_pop), 128'd0);
        chk("rst_cnt", 128'(outstanding_cnt), 128'd0);
        chk("rst_sel_err", 128'(sel_err), 128'd0);

        // Stray responses while empty must stall
        stray = 2'b11;
        cyc(); #2;
        chk("stray_ready", 128'(port_rsp_ready), 128'd0);
        chk("stray_vld", 128'(rsp_vld), 128'd0);
        stray = 2'b00;
        cyc();

        // Combinational request routing; vld never spans a clock edge here
        for (int i = 0; i < 8; i++) begin
            set_req(vt[i].rtype, i);
            req_vld  = vt[i].vld;
            port_rdy = vt[i].prdy;
            #2;
            chk("tbl_rdy", 128'(req_rdy), 128'(vt[i].exp_rdy));
            chk("tbl_valid", 128'(port_req_valid), 128'(vt[i].exp_valid));
            chk("tbl_pd0", 128'(port_req_pd[RQW-1:0]), 128'(req_pd));
            chk("tbl_pd1", 128'(port_req_pd[2*RQW-1:RQW]), 128'(req_pd));
            #1;
            req_vld = 1'b0;
            cyc();
        end
        port_rdy = 2'b11;
        chk("tbl_no_push", 128'(outstanding_cnt), 128'd0);

        // In-order reassembly: port 1 is ready early but must wait behind port 0
        send_req(2'd0, 0);
        send_req(2'd1, 3);
        send_req(2'd0, 1);
        chk("ord_cnt3", 128'(outstanding_cnt), 128'd3);
        en = 2'b10;
        repeat (4) begin
            #2;
            chk("ord_hold_vld", 128'(rsp_vld), 128'd0);
            chk("ord_hold_ready", 128'(port_rsp_ready), 128'b01);
            cyc();
        end
        base = rx_cnt;
        drain(50, 1'b0);
        chk("ord_beats", 128'(rx_cnt - base), 128'd7);

        // Fill to ORD_DEPTH, the 17th stalls; one pop lets it in the next cycle only
        for (int k = 0; k < 16; k++) send_req(2'(k % 2), 0);
        chk("full_cnt", 128'(outstanding_cnt), 128'd16);
        set_req(2'd1, 0);
        req_vld = 1'b1;
        #2;
        chk("full_rdy", 128'(req_rdy), 128'd0);
        chk("full_valid", 128'(port_req_valid), 128'd0);
        en = 2'b01;
        cyc(); #2;
        chk("full_rsp_vld", 128'(rsp_vld), 128'd1);
        chk("full_nobypass", 128'(req_rdy), 128'd0);
        chk("full_nobypass_v", 128'(port_req_valid), 128'd0);
        en = 2'b00;
        @(posedge clk); #3;
        chk("full_cnt15", 128'(outstanding_cnt), 128'd15);
        chk("full_rdy_after", 128'(req_rdy), 128'd1);
        chk("full_valid_after", 128'(port_req_valid), 128'b10);
        @(negedge clk);
        if (req_rdy) push_model(2'd1, 0);
        cyc();
        req_vld = 1'b0;
        chk("full_cnt16", 128'(outstanding_cnt), 128'd16);
        drain(200, 1'b1);

        // Simultaneous push/pop at occupancy 5 over enough requests to wrap pointers
        for (int k = 0; k < 5; k++) send_req(2'(k % 2), 0);
        en = 2'b11;
        for (int k = 0; k < 40; k++) begin
            set_req(2'(k % 2), 0);
            req_vld = 1'b1;
            @(negedge clk);
            chk("ovl_rdy", 128'(req_rdy), 128'd1);
            if (req_rdy) push_model(2'(k % 2), 0);
            cyc();
            chk("ovl_cnt", 128'(outstanding_cnt), 128'd5);
        end
        req_vld = 1'b0;
        drain(100, 1'b1);

        // Out-of-range select stalls and sets the sticky error
        set_req(2'd3, 0);
        req_vld = 1'b1;
        #2;
        chk("sel_rdy", 128'(req_rdy), 128'd0);
        chk("sel_valid", 128'(port_req_valid), 128'd0);
        chk("sel_err_pre", 128'(sel_err), 128'd0);
        cyc();
        chk("sel_err_set", 128'(sel_err), 128'd1);
        req_vld  = 1'b0;
        req_type = 2'd0;
        repeat (3) cyc();
        chk("sel_err_sticky", 128'(sel_err), 128'd1);
        chk("sel_cnt", 128'(outstanding_cnt), 128'd0);

        // Credit pop: one-cycle latency, single-cycle pulse, out-of-range dropped
        ct[0] = 2'd1; ce[0] = 2'b10;
        ct[1] = 2'd0; ce[1] = 2'b01;
        ct[2] = 2'd3; ce[2] = 2'b00;
        for (int i = 0; i < 3; i++) begin
            cdt_type = ct[i];
            cdt_pop  = 1'b1;
            #2;
            chk("cdt_pre", 128'(port_cdt_pop), 128'd0);
            cyc();
            cdt_pop = 1'b0;
            #2;
            chk("cdt_pulse", 128'(port_cdt_pop), 128'(ce[i]));
            cyc(); #2;
            chk("cdt_clear", 128'(port_cdt_pop), 128'd0);
            cyc();
        end

        // Reset in the middle of a 4-beat transfer
        send_req(2'd1, 3);
        base = rx_cnt;
        en = 2'b10;
        c = 0;
        while (rx_cnt < base + 2 && c < 20) begin
            cyc();
            c++;
        end
        chk("mid_beats", 128'(rx_cnt - base), 128'd2);
        rst = 1'b1;
        en  = 2'b00;
        cyc();
        rst = 1'b0;
        chk("mid_cnt", 128'(outstanding_cnt), 128'd0);
        chk("mid_sel_err", 128'(sel_err), 128'd0);
        #2;
        chk("mid_rsp_vld", 128'(rsp_vld), 128'd0);
        chk("mid_rsp_ready", 128'(port_rsp_ready), 128'd0);
        chk("mid_req_rdy", 128'(req_rdy), 128'd1);
        cyc();
        // A single-beat request must pop on its only beat if the beat counter was cleared
        send_req(2'd1, 0);
        base = rx_cnt;
        drain(20, 1'b0);
        chk("mid_single", 128'(rx_cnt - base), 128'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
